// File: rtl/breath_pkg.sv
// Shared types and constants for the breathing-LED ramp generator.
package breath_pkg;

  // Phases of one breath: climb, dwell at peak, descend, dwell at floor.
  typedef enum logic [1:0] {
    RISE    = 2'd0,
    HOLD_HI = 2'd1,
    FALL    = 2'd2,
    HOLD_LO = 2'd3
  } breath_state_e;

  localparam int CLK_DIV_DEF = 100;
  localparam int STEPS_DEF   = 1000;

  // Bits needed to hold a duty value in 0..steps inclusive.
  function automatic int duty_width(input int steps);
    return $clog2(steps + 1);
  endfunction

endpackage

// File: rtl/breath_tick_div.sv
// Prescaler plus PWM frame counter: emits the tick pulse, the frame
// position and a combinational frame_end strobe for the ramp FSM.
module breath_tick_div #(
  parameter int CLK_DIV = 100,
  parameter int STEPS   = 1000,
  parameter int DUTY_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              tick,
  output logic [DUTY_W-1:0] pwm_cnt,
  output logic              frame_end
);

  localparam int                DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DUTY_W-1:0] PWM_LAST = DUTY_W'(STEPS - 1);

  logic [DIV_W-1:0]  div_q, div_d;
  logic [DUTY_W-1:0] pwm_q, pwm_d;
  logic              tick_q, tick_d;
  logic              div_wrap;

  // Next-state: divider counts while enabled; the frame counter advances
  // in the same edge that raises tick so both are visible together.
  always_comb begin
    div_wrap = en && (div_q == DIV_LAST);
    div_d    = div_q;
    pwm_d    = pwm_q;
    tick_d   = div_wrap;
    if (div_wrap) begin
      div_d = '0;
      pwm_d = (pwm_q == PWM_LAST) ? '0 : pwm_q + DUTY_W'(1);
    end else if (en) begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // State registers; reset discards any partial tick or frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      pwm_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      pwm_q  <= pwm_d;
      tick_q <= tick_d;
    end
  end

  // Pulses are suppressed while paused, including one already registered.
  assign tick      = tick_q & en;
  assign pwm_cnt   = pwm_q;
  assign frame_end = div_wrap && (pwm_q == PWM_LAST);

endmodule

// File: rtl/breath_ramp_gen.sv
// Breathing-LED timing and brightness source: triangular duty ramp with
// optional dwell at peak and floor, updated once per PWM frame.
module breath_ramp_gen
  import breath_pkg::*;
#(
  parameter int CLK_DIV     = CLK_DIV_DEF,
  parameter int STEPS       = STEPS_DEF,
  parameter int HOLD_FRAMES = 0,
  parameter int DUTY_W      = duty_width(STEPS_DEF),
  parameter int RATE_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [RATE_W-1:0] ramp_step,
  output logic              tick,
  output logic [DUTY_W-1:0] pwm_cnt,
  output logic              frame_start,
  output logic [DUTY_W-1:0] duty,
  output logic              falling,
  output logic              cycle_done
);

  // Sum is one bit wider than the wider operand so duty+step never wraps,
  // even when ramp_step is wider than duty.
  localparam int                SUM_W     = ((DUTY_W > RATE_W) ? DUTY_W : RATE_W) + 1;
  localparam logic [SUM_W-1:0]  STEPS_S   = SUM_W'(STEPS);
  localparam logic [DUTY_W-1:0] DUTY_MAX  = DUTY_W'(STEPS);
  localparam int                HOLD_W    = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_FRAMES > 0) ? HOLD_FRAMES - 1 : 0);
  localparam bit                NO_HOLD   = (HOLD_FRAMES == 0);

  breath_state_e     state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              falling_q, falling_d;
  logic              fs_q, fs_d;
  logic              cd_q, cd_d;
  logic              frame_end;
  logic [SUM_W-1:0]  duty_ext, step_ext, sum;

  breath_tick_div #(
    .CLK_DIV (CLK_DIV),
    .STEPS   (STEPS),
    .DUTY_W  (DUTY_W)
  ) u_tick_div (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .tick      (tick),
    .pwm_cnt   (pwm_cnt),
    .frame_end (frame_end)
  );

  // Ramp FSM next-state: only a frame boundary moves duty or state.
  always_comb begin
    duty_ext = SUM_W'(duty_q);
    step_ext = SUM_W'(ramp_step);
    sum      = duty_ext + step_ext;
    state_d  = state_q;
    duty_d   = duty_q;
    hold_d   = hold_q;
    fs_d     = frame_end;
    cd_d     = 1'b0;
    if (frame_end) begin
      case (state_q)
        RISE: begin
          if (sum >= STEPS_S) begin
            duty_d = DUTY_MAX;
            hold_d = '0;
            if (NO_HOLD) state_d = FALL;
            else         state_d = HOLD_HI;
          end else begin
            duty_d = sum[DUTY_W-1:0];
          end
        end
        HOLD_HI: begin
          if (hold_q == HOLD_LAST) begin
            state_d = FALL;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        FALL: begin
          // step < duty here guarantees the narrowed step fits in DUTY_W.
          if (step_ext >= duty_ext) begin
            duty_d = '0;
            hold_d = '0;
            if (NO_HOLD) begin
              state_d = RISE;
              cd_d    = 1'b1;
            end else begin
              state_d = HOLD_LO;
            end
          end else begin
            duty_d = duty_q - DUTY_W'(ramp_step);
          end
        end
        HOLD_LO: begin
          if (hold_q == HOLD_LAST) begin
            state_d = RISE;
            hold_d  = '0;
            cd_d    = 1'b1;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        default: state_d = RISE;
      endcase
    end
    falling_d = (state_d == FALL) || (state_d == HOLD_HI);
  end

  // Ramp state registers; reset returns to the start of a rise at duty 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RISE;
      duty_q    <= '0;
      hold_q    <= '0;
      falling_q <= 1'b0;
      fs_q      <= 1'b0;
      cd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      duty_q    <= duty_d;
      hold_q    <= hold_d;
      falling_q <= falling_d;
      fs_q      <= fs_d;
      cd_q      <= cd_d;
    end
  end

  assign duty        = duty_q;
  assign falling     = falling_q;
  assign frame_start = fs_q & en;
  assign cycle_done  = cd_q & en;

endmodule

// File: tb/tb_breath_ramp_gen.sv
// Directed bench: CLK_DIV=4, STEPS=8 (32 clocks per frame); instance a has
// HOLD_FRAMES=2, instance z has HOLD_FRAMES=0.
module tb_breath_ramp_gen;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, en_a, rst_z, en_z;
  logic [7:0] step_a, step_z;
  logic       a_tick, a_fs, a_fall, a_cd, z_tick, z_fs, z_fall, z_cd;
  logic [3:0] a_pwm, a_duty, z_pwm, z_duty;

  breath_ramp_gen #(.CLK_DIV(4), .STEPS(8), .HOLD_FRAMES(2), .DUTY_W(4), .RATE_W(8)) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .ramp_step(step_a),
    .tick(a_tick), .pwm_cnt(a_pwm), .frame_start(a_fs),
    .duty(a_duty), .falling(a_fall), .cycle_done(a_cd)
  );

  breath_ramp_gen #(.CLK_DIV(4), .STEPS(8), .HOLD_FRAMES(0), .DUTY_W(4), .RATE_W(8)) dut_z (
    .clk(clk), .rst(rst_z), .en(en_z), .ramp_step(step_z),
    .tick(z_tick), .pwm_cnt(z_pwm), .frame_start(z_fs),
    .duty(z_duty), .falling(z_fall), .cycle_done(z_cd)
  );

  int checks = 0;
  int errors = 0;
  bit sel = 1'b0;

  logic       o_tick, o_fs, o_fall, o_cd;
  logic [3:0] o_pwm, o_duty;

  always_comb begin
    o_tick = sel ? z_tick : a_tick;
    o_fs   = sel ? z_fs   : a_fs;
    o_fall = sel ? z_fall : a_fall;
    o_cd   = sel ? z_cd   : a_cd;
    o_pwm  = sel ? z_pwm  : a_pwm;
    o_duty = sel ? z_duty : a_duty;
  end

  int nom_d [14] = '{0, 2, 4, 6, 8, 8, 8, 6, 4, 2, 0, 0, 0, 2};
  int sat_d [12] = '{0, 3, 6, 8, 8, 8, 5, 2, 0, 0, 0, 3};
  int zh_d  [6]  = '{0, 4, 8, 4, 0, 4};

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp))
      else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  // Check frame cycles c0..c1-1 sampled on successive falling edges.
  task automatic run_cycles(input bit first, input int c0, input int c1,
                            input int ed, input bit ef, input bit ecd);
    for (int c = c0; c < c1; c++) begin
      chk("tick",        32'(o_tick), int'((c % 4 == 0) && !(first && c == 0)));
      chk("pwm_cnt",     32'(o_pwm),  c / 4);
      chk("frame_start", 32'(o_fs),   int'((c == 0) && !first));
      chk("cycle_done",  32'(o_cd),   int'((c == 0) && ecd));
      chk("duty",        32'(o_duty), ed);
      chk("falling",     32'(o_fall), int'(ef));
      @(negedge clk);
    end
  endtask

  task automatic run_frame(input int k, input int ed, input bit ef, input bit ecd);
    run_cycles(k == 0, 0, 32, ed, ef, ecd);
    $display("frame %0d: duty=%0d falling=%0d cycle_done=%0d", k, ed, ef, ecd);
  endtask

  // One-cycle reset with en left high; reset must win and clear everything.
  task automatic do_reset(input string tag);
    if (sel) rst_z = 1'b1; else rst_a = 1'b1;
    @(negedge clk);
    chk({tag, "_duty"},    32'(o_duty), 0);
    chk({tag, "_pwm"},     32'(o_pwm),  0);
    chk({tag, "_falling"}, 32'(o_fall), 0);
    chk({tag, "_tick"},    32'(o_tick), 0);
    chk({tag, "_fs"},      32'(o_fs),   0);
    chk({tag, "_cd"},      32'(o_cd),   0);
    if (sel) rst_z = 1'b0; else rst_a = 1'b0;
    $display("reset %s", tag);
  endtask

  initial begin
    rst_a = 1'b1; en_a = 1'b1; step_a = 8'd2;
    rst_z = 1'b1; en_z = 1'b1; step_z = 8'd4;
    @(negedge clk);
    @(negedge clk);

    // Nominal ramp, step 2, two extra dwell frames.
    do_reset("nom_rst");
    for (int k = 0; k < 14; k++)
      run_frame(k, nom_d[k], (k >= 4) && (k <= 9), k == 12);

    // Saturation with step 3.
    step_a = 8'd3;
    do_reset("sat_rst");
    for (int k = 0; k < 12; k++)
      run_frame(k, sat_d[k], (k >= 3) && (k <= 7), k == 10);

    // Pause, step change, then reset while holding at the peak.
    step_a = 8'd2;
    do_reset("pause_rst");
    run_frame(0, 0, 1'b0, 1'b0);
    run_cycles(1'b0, 0, 22, 2, 1'b0, 1'b0);
    en_a = 1'b0;
    for (int i = 0; i < 50; i++) begin
      chk("pause_tick", 32'(o_tick), 0);
      chk("pause_fs",   32'(o_fs),   0);
      chk("pause_cd",   32'(o_cd),   0);
      chk("pause_pwm",  32'(o_pwm),  5);
      chk("pause_duty", 32'(o_duty), 2);
      @(negedge clk);
    end
    en_a = 1'b1;
    run_cycles(1'b0, 22, 32, 2, 1'b0, 1'b0);
    $display("frame 1: paused 50 clocks at pwm_cnt=5, duty=2");
    run_cycles(1'b0, 0, 10, 4, 1'b0, 1'b0);
    step_a = 8'd1;
    run_cycles(1'b0, 10, 32, 4, 1'b0, 1'b0);
    $display("frame 2: duty=4, ramp_step changed 2->1 mid-frame");
    run_frame(3, 5, 1'b0, 1'b0);
    run_frame(4, 6, 1'b0, 1'b0);
    run_frame(5, 7, 1'b0, 1'b0);
    run_frame(6, 8, 1'b1, 1'b0);
    run_cycles(1'b0, 0, 12, 8, 1'b1, 1'b0);
    do_reset("hold_rst");
    run_frame(0, 0, 1'b0, 1'b0);
    run_frame(1, 1, 1'b0, 1'b0);

    // Zero dwell on the second instance, step 4.
    sel = 1'b1;
    do_reset("zh_rst");
    for (int k = 0; k < 6; k++)
      run_frame(k, zh_d[k], (k == 2) || (k == 3), k == 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
